dmem_bus_bridge: RTL

Data-memory bridge between the core's single-cycle data port and a variable-latency request/grant bus. It sits directly downstream of the CPU core's memory interface (`mem_ren`/`mem_wen`/`mem_addr`/`mem_dout`/`mem_din`). It adds a stall output that freezes the pipeline, a one-entry posted-write buffer and a read timeout. Only one bus transfer is outstanding at any time.

---
 rtl/dmem_bus_bridge.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: core data port to request/grant bus bridge.
// Stalls the core, posts writes (WRITE_BUFFER_EN), times out reads.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   core_ren/wen/addr/wdata  core request (held while core_stall)
//   core_rdata               load data, valid when the read stall drops
//   core_stall               combinational pipeline freeze
//   bus_req/we/addr/wdata    registered bus transfer request
//   bus_gnt                  transfer accepted when bus_req & bus_gnt
//   bus_rvalid/rdata         read response
//   bus_err                  sticky read timeout flag
//
// Macro WRITE_BUFFER_EN: one-entry posted write buffer.
// Undefined: writes stall until their own grant.

module dmem_bus_bridge #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_ren,
  input  logic        core_wen,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE, WR_DRAIN, RD_REQ, RD_WAIT, RD_DONE
  } state_t;

  localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_nx;
  logic        wr_acc;
  logic        wr_done;
  logic        rd_start;
  logic        to_hit;
  logic [15:0] cnt;

  // The bus request registers double as the write buffer:
  // the buffer is full exactly while in WR_DRAIN.
  // wr_done marks the write half of a combined read+write
  // as taken, so the held core_wen is not captured twice.

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign to_hit = (cnt == TO);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (wr_acc)        state_nx = WR_DRAIN;
        else if (core_ren) state_nx = RD_REQ;
      end
      WR_DRAIN: begin
        if (bus_gnt) begin
          if (wr_acc)        state_nx = WR_DRAIN;
          else if (core_ren) state_nx = RD_REQ;
          else               state_nx = IDLE;
        end
      end
      RD_REQ: begin
        if (bus_gnt) state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus_rvalid || to_hit) state_nx = RD_DONE;
      end
      RD_DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wr_acc     = 1'b0;
    core_stall = 1'b0;
`ifdef WRITE_BUFFER_EN
    wr_acc = core_wen & ~wr_done &
             ((state == IDLE) |
              ((state == WR_DRAIN) & bus_gnt));
    core_stall = (core_ren & (state != RD_DONE)) |
                 (core_wen & (state == WR_DRAIN) & ~bus_gnt);
`else
    wr_acc = core_wen & ~wr_done & (state == IDLE);
    core_stall = (core_ren & (state != RD_DONE)) |
                 (core_wen & ~wr_done &
                  ~((state == WR_DRAIN) & bus_gnt));
`endif
  end

  assign rd_start = (state_nx == RD_REQ) && (state != RD_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      core_rdata <= '0;
      bus_err    <= 1'b0;
      cnt        <= '0;
      wr_done    <= 1'b0;
    end else begin
      if (wr_acc) begin
        bus_req   <= 1'b1;
        bus_we    <= 1'b1;
        bus_addr  <= core_addr;
        bus_wdata <= core_wdata;
      end else if (rd_start) begin
        bus_req  <= 1'b1;
        bus_we   <= 1'b0;
        bus_addr <= core_addr;
      end else if (bus_gnt) begin
        bus_req <= 1'b0;
      end

      if ((state == RD_REQ) && bus_gnt) cnt <= '0;
      else if (state == RD_WAIT)        cnt <= cnt + 16'd1;

      if (state == RD_WAIT) begin
        if (bus_rvalid) begin
          core_rdata <= bus_rdata;
        end else if (to_hit) begin
          core_rdata <= ERR_DATA;
          bus_err    <= 1'b1;
        end
      end

      if (wr_acc && core_ren)    wr_done <= 1'b1;
      else if (state == RD_DONE) wr_done <= 1'b0;
    end
  end

endmodule
